alu_bist: RTL and testbench
===========================

# alu_bist

Synthesizable built-in self-test engine for the `myalu` ALU. It drives the ALU's `A`/`B`/`opcode` inputs from an internal directed-vector ROM and samples `result`/`carryout`/`overflow`/`zero`. It compares them against expected values and reports pass/fail counts. It sits beside `myalu` in the datapath and takes over its inputs during power-on or on-demand self-test.

## Interface

Parameters:
- `NUMBITS`, 8: ALU operand/result width.
- `NUMVEC`, 24: number of vectors in the ROM (3 per opcode).
- `ALU_LAT`, 1: ALU clock cycles from input change to valid outputs; range 1–15.
- `CNT_W`, 8: width of the counters.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: single-cycle pulse that begins a run.
- `busy`, out, 1: run in progress.
- `done`, out, 1: run complete; held until the next start or reset.
- `pass`, out, 1: `done` and `fail_cnt == 0`.
- `total_cnt`, out, `CNT_W`: vectors checked.
- `fail_cnt`, out, `CNT_W`: vectors that mismatched.
- `alu_a`, out, `NUMBITS`: drives ALU `A`.
- `alu_b`, out, `NUMBITS`: drives ALU `B`.
- `alu_opcode`, out, 3: drives ALU `opcode`.
- `alu_result`, in, `NUMBITS`: ALU result.
- `alu_carryout`, in, 1: ALU carry out.
- `alu_overflow`, in, 1: ALU overflow.
- `alu_zero`, in, 1: ALU zero flag.

## Operation

- Opcode map:
  - 000 unsigned add; 001 signed add; 010 unsigned sub; 011 signed sub.
  - 100 AND; 101 OR; 110 XOR; 111 A>>1 (B ignored).
- ROM entry fields: `a`, `b`, `op`, `exp_result`, `exp_zero`, `exp_carry`, `exp_ovf`, `chk_carry`, `chk_ovf`.
- Which fields are checked:
  - Result and zero are always checked.
  - Carry is checked only where `chk_carry=1` (opcodes 000/010).
  - Overflow is checked only where `chk_ovf=1` (opcodes 001/011).
- FSM states and transitions:
  - IDLE: on `start`, clear the counters, set index=0, go to APPLY.
  - APPLY (1 cycle): register ROM[index] onto `alu_a`/`alu_b`/`alu_opcode`, go to WAIT.
  - WAIT (`ALU_LAT` cycles, down-counter): go to CHECK.
  - CHECK (1 cycle): compare, increment `total_cnt`, increment `fail_cnt` on mismatch.
    - If index==NUMVEC-1, go to DONE.
    - Otherwise increment index and go to APPLY.
  - DONE: `done=1`; `start` restarts exactly as from IDLE.
- `start` is ignored while `busy`.
- ALU inputs hold stable from APPLY through CHECK. They keep the last vector in DONE and return to 0 only on reset.
- Counters saturate at 2^CNT_W−1 and do not wrap.
- Compares use `!==`-equivalent semantics on every checked bit; an X on an input counts as a mismatch.

## Timing

- Reset values: `busy=0`, `done=0`, `pass=0`, `total_cnt=0`, `fail_cnt=0`, `alu_a=0`, `alu_b=0`, `alu_opcode=0`, FSM in IDLE.
- `busy` rises the cycle after `start` is sampled and falls the cycle `done` rises.
- Per-vector latency is `ALU_LAT+2` cycles.
- A run lasts `NUMVEC*(ALU_LAT+2)` cycles from the first APPLY to `done`.
- `pass` and `done` assert in the same cycle. Counters are final at that cycle and stable afterwards.
- Reset asserted mid-run returns every output to its reset value on the next edge; no partial results are retained.
- `start` and `reset` in the same cycle: reset wins.

## Configuration

- `ALU_BIST_FAILLOG_EN` defined:
  - Adds outputs `first_fail_vld` (1) and `first_fail_idx` (`$clog2(NUMVEC)`).
  - On the first mismatch of a run, both are captured and then held until the next start or reset.
  - Both are cleared on reset and on start.
- Undefined: those ports and their registers are absent. All other behaviour is identical.

## Structure

- Package `alu_bist_pkg` holds:
  - the opcode localparams `OP_UADD` … `OP_DIV2`;
  - the typedef `alu_vec_t` for a ROM entry;
  - the FSM state enum `{S_IDLE, S_APPLY, S_WAIT, S_CHECK, S_DONE}`;
  - the constant vector table.
- Sub-module `alu_bist_rom`: combinational index→`alu_vec_t` lookup.
- Vector 0 is A=FF, B=01, op 000, expecting result 00, Z=1, C=1.
- All A>>1 vectors use A with bit pattern ≠ 0.

## Test plan

- Reference-correct ALU model, `ALU_LAT=1`, `start` pulse:
  - `done` rises 72 cycles after the first APPLY;
  - `total_cnt=24`, `fail_cnt=0`, `pass=1`.
- ALU model with the A>>1 opcode returning A unshifted: `fail_cnt=3`, `pass=0`; with the macro, `first_fail_idx=21`.
- ALU model with `carryout` stuck at 0: `fail_cnt` equals the number of vectors with `chk_carry=1` and `exp_carry=1` (≥1, vector 0).
  - Signed/logical vectors are not failed by the stuck carry.
- `ALU_LAT=3`, correct model: run length is 120 cycles and `pass=1`.
  - ALU inputs are verified stable across each 5-cycle vector window.
- Reset asserted at cycle 20 of a run: all outputs return to 0 next cycle.
  - A following `start` gives a clean full run with `total_cnt=24`.
- Edge cases:
  - `start` pulsed while `busy`: no effect on counts or timing.
  - `start` in DONE: counters clear and a second identical run completes.

Source files
------------

// File: rtl/alu_bist_pkg.sv
// alu_bist_pkg: shared definitions for the myalu built-in self-test engine.
//   - opcode encodings understood by myalu
//   - alu_vec_t: one directed-vector ROM entry
//   - bist_state_t: self-test sequencer states
//   - VEC_TABLE: directed vectors, three per opcode, 8-bit operands
// Unsigned subtract reports carryout=1 when a borrow occurs (A < B).
package alu_bist_pkg;

  localparam logic [2:0] OP_UADD = 3'b000;
  localparam logic [2:0] OP_SADD = 3'b001;
  localparam logic [2:0] OP_USUB = 3'b010;
  localparam logic [2:0] OP_SSUB = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_DIV2 = 3'b111;

  // Operand width of the stored vectors; wider/narrower ALUs get the
  // vectors zero-extended/truncated by the engine.
  localparam int unsigned VEC_W     = 8;
  localparam int unsigned ROM_DEPTH = 24;

  typedef struct packed {
    logic [VEC_W-1:0] a;
    logic [VEC_W-1:0] b;
    logic [2:0]       op;
    logic [VEC_W-1:0] exp_result;
    logic             exp_zero;
    logic             exp_carry;
    logic             exp_ovf;
    logic             chk_carry;
    logic             chk_ovf;
  } alu_vec_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_APPLY = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } bist_state_t;

  // Carry is meaningful only for unsigned arithmetic, overflow only for
  // signed arithmetic; the check enables follow from the opcode.
  function automatic alu_vec_t mk_vec(input logic [VEC_W-1:0] a,
                                      input logic [VEC_W-1:0] b,
                                      input logic [2:0]       op,
                                      input logic [VEC_W-1:0] res,
                                      input logic             z,
                                      input logic             c,
                                      input logic             v);
    alu_vec_t e;
    e.a          = a;
    e.b          = b;
    e.op         = op;
    e.exp_result = res;
    e.exp_zero   = z;
    e.exp_carry  = c;
    e.exp_ovf    = v;
    e.chk_carry  = (op == OP_UADD) || (op == OP_USUB);
    e.chk_ovf    = (op == OP_SADD) || (op == OP_SSUB);
    return e;
  endfunction

  localparam alu_vec_t VEC_TABLE [ROM_DEPTH] = '{
    //      a      b      op       result  Z     C     V
    mk_vec(8'hFF, 8'h01, OP_UADD, 8'h00, 1'b1, 1'b1, 1'b0),
    mk_vec(8'h12, 8'h34, OP_UADD, 8'h46, 1'b0, 1'b0, 1'b0),
    mk_vec(8'h80, 8'h90, OP_UADD, 8'h10, 1'b0, 1'b1, 1'b0),
    mk_vec(8'h7F, 8'h01, OP_SADD, 8'h80, 1'b0, 1'b0, 1'b1),
    mk_vec(8'h80, 8'hFF, OP_SADD, 8'h7F, 1'b0, 1'b0, 1'b1),
    mk_vec(8'h05, 8'hFB, OP_SADD, 8'h00, 1'b1, 1'b0, 1'b0),
    mk_vec(8'h10, 8'h01, OP_USUB, 8'h0F, 1'b0, 1'b0, 1'b0),
    mk_vec(8'h01, 8'h02, OP_USUB, 8'hFF, 1'b0, 1'b1, 1'b0),
    mk_vec(8'h55, 8'h55, OP_USUB, 8'h00, 1'b1, 1'b0, 1'b0),
    mk_vec(8'h80, 8'h01, OP_SSUB, 8'h7F, 1'b0, 1'b0, 1'b1),
    mk_vec(8'h7F, 8'hFF, OP_SSUB, 8'h80, 1'b0, 1'b0, 1'b1),
    mk_vec(8'h05, 8'h03, OP_SSUB, 8'h02, 1'b0, 1'b0, 1'b0),
    mk_vec(8'hF0, 8'h3C, OP_AND,  8'h30, 1'b0, 1'b0, 1'b0),
    mk_vec(8'hAA, 8'h55, OP_AND,  8'h00, 1'b1, 1'b0, 1'b0),
    mk_vec(8'hFF, 8'h81, OP_AND,  8'h81, 1'b0, 1'b0, 1'b0),
    mk_vec(8'h00, 8'h00, OP_OR,   8'h00, 1'b1, 1'b0, 1'b0),
    mk_vec(8'hA0, 8'h05, OP_OR,   8'hA5, 1'b0, 1'b0, 1'b0),
    mk_vec(8'h0F, 8'hF0, OP_OR,   8'hFF, 1'b0, 1'b0, 1'b0),
    mk_vec(8'hFF, 8'hFF, OP_XOR,  8'h00, 1'b1, 1'b0, 1'b0),
    mk_vec(8'hA5, 8'h0F, OP_XOR,  8'hAA, 1'b0, 1'b0, 1'b0),
    mk_vec(8'h12, 8'h34, OP_XOR,  8'h26, 1'b0, 1'b0, 1'b0),
    // Non-zero A so an ALU that skips the shift is always caught.
    mk_vec(8'h84, 8'h5A, OP_DIV2, 8'h42, 1'b0, 1'b0, 1'b0),
    mk_vec(8'h01, 8'hC3, OP_DIV2, 8'h00, 1'b1, 1'b0, 1'b0),
    mk_vec(8'hFF, 8'h00, OP_DIV2, 8'h7F, 1'b0, 1'b0, 1'b0)
  };

endpackage

// File: rtl/alu_bist_rom.sv
// alu_bist_rom: combinational index -> alu_vec_t lookup into VEC_TABLE.
// Ports:
//   idx_i  in  IDX_W      vector index
//   vec_o  out alu_vec_t  ROM entry (all-zero beyond the table)
module alu_bist_rom
  import alu_bist_pkg::*;
#(
  parameter int unsigned IDX_W = 5
) (
  input  logic [IDX_W-1:0] idx_i,
  output alu_vec_t         vec_o
);

  always_comb begin
    vec_o = '0;
    for (int unsigned i = 0; i < ROM_DEPTH; i++) begin
      if (idx_i == IDX_W'(i)) vec_o = VEC_TABLE[i];
    end
  end

endmodule

// File: rtl/alu_bist.sv
// alu_bist: built-in self-test engine for the myalu ALU.
// Applies each ROM vector to the ALU, waits ALU_LAT cycles, checks
// result/zero (always), carry (unsigned ops) and overflow (signed ops),
// and accumulates saturating total/fail counts.
// Ports:
//   clk, reset (sync, active-high), start (pulse)
//   busy, done, pass, total_cnt, fail_cnt    status / results
//   alu_a, alu_b, alu_opcode                 drive the ALU inputs
//   alu_result, alu_carryout, alu_overflow, alu_zero   ALU outputs
// Optional build macro ALU_BIST_FAILLOG_EN adds first_fail_vld and
// first_fail_idx, capturing the index of the first mismatching vector.
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int unsigned NUMBITS = 8,
  parameter int unsigned NUMVEC  = 24,
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   total_cnt,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic [NUMBITS-1:0] alu_a,
  output logic [NUMBITS-1:0] alu_b,
  output logic [2:0]         alu_opcode,
  input  logic [NUMBITS-1:0] alu_result,
  input  logic               alu_carryout,
  input  logic               alu_overflow,
  input  logic               alu_zero
`ifdef ALU_BIST_FAILLOG_EN
  ,
  output logic                       first_fail_vld,
  output logic [$clog2(NUMVEC)-1:0]  first_fail_idx
`endif
);

  localparam int unsigned IDX_W = $clog2(NUMVEC);

  bist_state_t        state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         wait_q, wait_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic [CNT_W-1:0]   fail_q, fail_d;
  logic [NUMBITS-1:0] a_q, a_d;
  logic [NUMBITS-1:0] b_q, b_d;
  logic [2:0]         op_q, op_d;
  alu_vec_t           rom_vec;
  logic               mismatch;

`ifdef ALU_BIST_FAILLOG_EN
  logic               ff_vld_q, ff_vld_d;
  logic [IDX_W-1:0]   ff_idx_q, ff_idx_d;
`endif

  alu_bist_rom #(
    .IDX_W(IDX_W)
  ) u_rom (
    .idx_i (idx_q),
    .vec_o (rom_vec)
  );

  // Case-inequality so an X/Z on any checked ALU output counts as a miss.
  always_comb begin
    mismatch = 1'b0;
    if (alu_result !== NUMBITS'(rom_vec.exp_result))          mismatch = 1'b1;
    if (alu_zero !== rom_vec.exp_zero)                        mismatch = 1'b1;
    if (rom_vec.chk_carry && (alu_carryout !== rom_vec.exp_carry)) mismatch = 1'b1;
    if (rom_vec.chk_ovf && (alu_overflow !== rom_vec.exp_ovf))     mismatch = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    total_d = total_q;
    fail_d  = fail_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
`ifdef ALU_BIST_FAILLOG_EN
    ff_vld_d = ff_vld_q;
    ff_idx_d = ff_idx_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          total_d = '0;
          fail_d  = '0;
          idx_d   = '0;
`ifdef ALU_BIST_FAILLOG_EN
          ff_vld_d = 1'b0;
          ff_idx_d = '0;
`endif
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        a_d     = NUMBITS'(rom_vec.a);
        b_d     = NUMBITS'(rom_vec.b);
        op_d    = rom_vec.op;
        wait_d  = 4'(ALU_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == '0) state_d = S_CHECK;
        else              wait_d  = wait_q - 4'd1;
      end
      S_CHECK: begin
        if (total_q != '1) total_d = total_q + CNT_W'(1);
        if (mismatch) begin
          if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
`ifdef ALU_BIST_FAILLOG_EN
          if (!ff_vld_q) begin
            ff_vld_d = 1'b1;
            ff_idx_d = idx_q;
          end
`endif
        end
        if (idx_q == IDX_W'(NUMVEC - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_APPLY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
      total_q <= '0;
      fail_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
`ifdef ALU_BIST_FAILLOG_EN
      ff_vld_q <= 1'b0;
      ff_idx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      total_q <= total_d;
      fail_q  <= fail_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
`ifdef ALU_BIST_FAILLOG_EN
      ff_vld_q <= ff_vld_d;
      ff_idx_q <= ff_idx_d;
`endif
    end
  end

  assign busy       = (state_q == S_APPLY) || (state_q == S_WAIT) || (state_q == S_CHECK);
  assign done       = (state_q == S_DONE);
  assign pass       = done && (fail_q == '0);
  assign total_cnt  = total_q;
  assign fail_cnt   = fail_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;
`ifdef ALU_BIST_FAILLOG_EN
  assign first_fail_vld = ff_vld_q;
  assign first_fail_idx = ff_idx_q;
`endif

endmodule

// File: tb/tb_alu_bist.sv
module tb_alu_bist;

  localparam int NV = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start_pulse = 1'b0;
  int   cur  = 0;   // 0: LAT=1, 1: LAT=3, 2: LAT=1 with 4-bit counters
  int   mode = 0;   // ALU fault: 0 none, 1 shift skipped, 2 carry stuck 0, 3 random, 4 result inverted
  int   n_total = 0;
  int   n_bad   = 0;

  logic [7:0] cmask [NV];

  typedef struct { logic [7:0] a; logic [7:0] b; logic [2:0] op; } stim_t;
  stim_t vt [NV];

  // DUT signals
  logic st1, st3, st4;
  logic bz1, dn1, ps1, bz3, dn3, ps3, bz4, dn4, ps4;
  logic [7:0] tot1, fl1, tot3, fl3;
  logic [3:0] tot4, fl4;
  logic [7:0] a1, b1, a3, b3, a4, b4;
  logic [2:0] op1, op3, op4;
  logic [10:0] p1, p4, p3a, p3b, p3c;
`ifdef ALU_BIST_FAILLOG_EN
  logic ffv1, ffv3, ffv4;
  logic [4:0] ffi1, ffi3, ffi4;
`endif

  assign st1 = start_pulse && (cur == 0);
  assign st3 = start_pulse && (cur == 1);
  assign st4 = start_pulse && (cur == 2);

  alu_bist #(.NUMBITS(8), .NUMVEC(24), .ALU_LAT(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(rst), .start(st1), .busy(bz1), .done(dn1), .pass(ps1),
    .total_cnt(tot1), .fail_cnt(fl1), .alu_a(a1), .alu_b(b1), .alu_opcode(op1),
    .alu_result(p1[10:3]), .alu_carryout(p1[2]), .alu_overflow(p1[1]), .alu_zero(p1[0])
`ifdef ALU_BIST_FAILLOG_EN
    , .first_fail_vld(ffv1), .first_fail_idx(ffi1)
`endif
  );

  alu_bist #(.NUMBITS(8), .NUMVEC(24), .ALU_LAT(3), .CNT_W(8)) dut3 (
    .clk(clk), .reset(rst), .start(st3), .busy(bz3), .done(dn3), .pass(ps3),
    .total_cnt(tot3), .fail_cnt(fl3), .alu_a(a3), .alu_b(b3), .alu_opcode(op3),
    .alu_result(p3c[10:3]), .alu_carryout(p3c[2]), .alu_overflow(p3c[1]), .alu_zero(p3c[0])
`ifdef ALU_BIST_FAILLOG_EN
    , .first_fail_vld(ffv3), .first_fail_idx(ffi3)
`endif
  );

  alu_bist #(.NUMBITS(8), .NUMVEC(24), .ALU_LAT(1), .CNT_W(4)) dut4 (
    .clk(clk), .reset(rst), .start(st4), .busy(bz4), .done(dn4), .pass(ps4),
    .total_cnt(tot4), .fail_cnt(fl4), .alu_a(a4), .alu_b(b4), .alu_opcode(op4),
    .alu_result(p4[10:3]), .alu_carryout(p4[2]), .alu_overflow(p4[1]), .alu_zero(p4[0])
`ifdef ALU_BIST_FAILLOG_EN
    , .first_fail_vld(ffv4), .first_fail_idx(ffi4)
`endif
  );

  // Reference ALU: returns {result, carry, overflow, zero}.
  function automatic logic [10:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
    logic [8:0] s;
    logic [7:0] r;
    logic c, o;
    c = 1'b0; o = 1'b0; s = '0;
    case (op)
      3'd0, 3'd1: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0];
        c = s[8];
        o = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'd2, 3'd3: begin
        r = a - b;
        c = (a < b);
        o = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = a >> 1;
    endcase
    return {r, c, o, (r == 8'h00)};
  endfunction

  function automatic int find_vec(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    for (int i = 0; i < NV; i++)
      if (vt[i].a == a && vt[i].b == b && vt[i].op == op) return i;
    return -1;
  endfunction

  // ALU as seen by the DUT, with the currently selected fault.
  function automatic logic [10:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op);
    logic [10:0] v;
    int k;
    v = alu_ref(a, b, op);
    case (mode)
      1: if (op == 3'd7) v[10:3] = a;
      2: v[2] = 1'b0;
      3: begin
        k = find_vec(a, b, op);
        if (k >= 0) v[10:3] = v[10:3] ^ cmask[k];
      end
      4: v[10:3] = ~v[10:3];
      default: ;
    endcase
    return v;
  endfunction

  always @(posedge clk) begin
    p1  <= alu_model(a1, b1, op1);
    p4  <= alu_model(a4, b4, op4);
    p3a <= alu_model(a3, b3, op3);
    p3b <= p3a;
    p3c <= p3b;
  end

  // Expected mismatch count / first failing index from the checking rules.
  task automatic predict(output int nfail, output int first);
    logic [10:0] r, f;
    logic m;
    nfail = 0; first = -1;
    for (int i = 0; i < NV; i++) begin
      r = alu_ref(vt[i].a, vt[i].b, vt[i].op);
      f = alu_model(vt[i].a, vt[i].b, vt[i].op);
      m = (r[10:3] != f[10:3]) || (r[0] != f[0]);
      if ((vt[i].op == 3'd0 || vt[i].op == 3'd2) && r[2] != f[2]) m = 1'b1;
      if ((vt[i].op == 3'd1 || vt[i].op == 3'd3) && r[1] != f[1]) m = 1'b1;
      if (m) begin
        nfail++;
        if (first < 0) first = i;
      end
    end
  endtask

  // Selected-DUT view
  logic o_busy, o_done, o_pass;
  logic [7:0] o_tot, o_fail, o_a, o_b;
  logic [2:0] o_op;
`ifdef ALU_BIST_FAILLOG_EN
  logic o_ffv;
  logic [4:0] o_ffi;
`endif
  always_comb begin
    case (cur)
      0: begin
        o_busy = bz1; o_done = dn1; o_pass = ps1; o_tot = tot1; o_fail = fl1;
        o_a = a1; o_b = b1; o_op = op1;
      end
      1: begin
        o_busy = bz3; o_done = dn3; o_pass = ps3; o_tot = tot3; o_fail = fl3;
        o_a = a3; o_b = b3; o_op = op3;
      end
      default: begin
        o_busy = bz4; o_done = dn4; o_pass = ps4; o_tot = {4'h0, tot4}; o_fail = {4'h0, fl4};
        o_a = a4; o_b = b4; o_op = op4;
      end
    endcase
  end
`ifdef ALU_BIST_FAILLOG_EN
  always_comb begin
    case (cur)
      0:       begin o_ffv = ffv1; o_ffi = ffi1; end
      1:       begin o_ffv = ffv3; o_ffi = ffi3; end
      default: begin o_ffv = ffv4; o_ffi = ffi4; end
    endcase
  end
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_pass"}, 32'(o_pass), 0);
    chk({tag, "_total"}, 32'(o_tot), 0);
    chk({tag, "_fail"}, 32'(o_fail), 0);
    chk({tag, "_alu_in"}, 32'({o_a, o_b, o_op}), 0);
`ifdef ALU_BIST_FAILLOG_EN
    chk({tag, "_ffv"}, 32'(o_ffv), 0);
`endif
  endtask

  typedef struct {
    int sel;
    int mode;
    int exp_total;
    int exp_fail;   // -1: take from the fault model
    int exp_ff;     // first failing index, -1 none, ignored when exp_fail < 0
    bit spurious;
    bit chk_bus;
  } scen_t;

  task automatic run(input scen_t s);
    int lat, cyc, ef, eff, win, v;
    stim_t e;
    lat = (s.sel == 1) ? 3 : 1;
    win = lat + 2;
    mode = s.mode;
    cur = s.sel;
    if (s.mode == 3) begin
      for (int i = 0; i < NV; i++)
        cmask[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
    end
    ef = s.exp_fail; eff = s.exp_ff;
    if (ef < 0) predict(ef, eff);
    #1;
    start_pulse = 1'b1;
    tick;
    start_pulse = 1'b0;
    chk("busy_after_start", 32'(o_busy), 1);
    chk("done_after_start", 32'(o_done), 0);
    chk("total_cleared", 32'(o_tot), 0);
    chk("fail_cleared", 32'(o_fail), 0);
    cyc = 0;
    while (!o_done && cyc < 2000) begin
      if (s.spurious && (cyc == 10 || cyc == 40)) start_pulse = 1'b1;
      tick;
      start_pulse = 1'b0;
      cyc++;
      if (s.chk_bus && !o_done) begin
        v = (cyc - 1) / win;
        e = vt[v];
        chk("bus_stable", 32'({o_a, o_b, o_op}), 32'({e.a, e.b, e.op}));
      end
    end
    chk("run_length", 32'(cyc), 32'(NV * win));
    chk("busy_at_done", 32'(o_busy), 0);
    chk("total_cnt", 32'(o_tot), 32'(s.exp_total));
    chk("fail_cnt", 32'(o_fail), 32'(ef));
    chk("pass", 32'(o_pass), 32'(ef == 0));
`ifdef ALU_BIST_FAILLOG_EN
    chk("first_fail_vld", 32'(o_ffv), 32'(eff >= 0));
    if (eff >= 0) chk("first_fail_idx", 32'(o_ffi), 32'(eff));
`endif
    e = vt[NV-1];
    chk("bus_held_last", 32'({o_a, o_b, o_op}), 32'({e.a, e.b, e.op}));
    repeat (3) tick;
    chk("done_held", 32'(o_done), 1);
    chk("total_stable", 32'(o_tot), 32'(s.exp_total));
    chk("fail_stable", 32'(o_fail), 32'(ef));
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    scen_t sc [8];
    vt = '{
      '{8'hFF, 8'h01, 3'd0}, '{8'h12, 8'h34, 3'd0}, '{8'h80, 8'h90, 3'd0},
      '{8'h7F, 8'h01, 3'd1}, '{8'h80, 8'hFF, 3'd1}, '{8'h05, 8'hFB, 3'd1},
      '{8'h10, 8'h01, 3'd2}, '{8'h01, 8'h02, 3'd2}, '{8'h55, 8'h55, 3'd2},
      '{8'h80, 8'h01, 3'd3}, '{8'h7F, 8'hFF, 3'd3}, '{8'h05, 8'h03, 3'd3},
      '{8'hF0, 8'h3C, 3'd4}, '{8'hAA, 8'h55, 3'd4}, '{8'hFF, 8'h81, 3'd4},
      '{8'h00, 8'h00, 3'd5}, '{8'hA0, 8'h05, 3'd5}, '{8'h0F, 8'hF0, 3'd5},
      '{8'hFF, 8'hFF, 3'd6}, '{8'hA5, 8'h0F, 3'd6}, '{8'h12, 8'h34, 3'd6},
      '{8'h84, 8'h5A, 3'd7}, '{8'h01, 8'hC3, 3'd7}, '{8'hFF, 8'h00, 3'd7}
    };
    for (int i = 0; i < NV; i++) cmask[i] = 8'h00;

    //        sel mode total fail ff  spur bus
    sc[0] = '{0,  0,   24,   0,  -1,  0,   0};
    sc[1] = '{0,  1,   24,   3,  21,  0,   0};
    sc[2] = '{0,  2,   24,   3,   0,  0,   0};
    sc[3] = '{1,  0,   24,   0,  -1,  0,   1};
    sc[4] = '{0,  0,   24,   0,  -1,  1,   0};
    sc[5] = '{0,  3,   24,  -1,  -1,  0,   0};
    sc[6] = '{2,  4,   15,  15,   0,  0,   0};
    sc[7] = '{0,  0,   24,   0,  -1,  0,   0};

    rst = 1'b1;
    repeat (2) tick;
    for (int d = 0; d < 3; d++) begin
      cur = d;
      #0;
      chk_idle_zero("reset");
    end
    rst = 1'b0;
    tick;

    for (int i = 0; i < 8; i++) run(sc[i]);

    // Reset partway through a run discards everything.
    cur = 0; mode = 0;
    start_pulse = 1'b1;
    tick;
    start_pulse = 1'b0;
    repeat (19) tick;
    chk("midrun_busy", 32'(o_busy), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk_idle_zero("midrun_reset");
    tick;
    chk("post_reset_idle", 32'(o_busy), 0);
    run(sc[0]);

    // start together with reset: reset wins and nothing starts.
    rst = 1'b1;
    start_pulse = 1'b1;
    tick;
    rst = 1'b0;
    start_pulse = 1'b0;
    chk_idle_zero("rst_and_start");
    tick;
    chk("rst_and_start_still_idle", 32'(o_busy), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
